// File: rtl/hdr_frame_capture.sv
// Camera capture front end: packs 8-bit camera bytes into BUS_W-bit words,
// checks frame geometry and rotates good frames through N_BUF DDR ring buffers.
module hdr_frame_capture #(
   parameter int BUS_W      = 128,
   parameter int ADDR_W     = 25,
   parameter int H_BYTES    = 1280,
   parameter int V_LINES    = 480,
   parameter int N_BUF      = 6,
   parameter int BUF_W      = 3,
   parameter int BUF_STRIDE = 'h25800,
   parameter int WORD_INC   = 4
) (
   input  logic              p_clk,
   input  logic              rst_n,
   input  logic [7:0]        data,
   input  logic              href,
   input  logic              vsync,
   input  logic              take_pic,
   input  logic              hdr_en,
   input  logic              exp_ack,
   output logic [BUS_W-1:0]  p_data,
   output logic              data_valid,
   output logic [ADDR_W-1:0] wr_address,
   output logic [BUF_W-1:0]  wr_buf,
   output logic [BUF_W-1:0]  last_frame,
   output logic              frame_done,
   output logic              frame_err,
   output logic              change_exp,
   output logic [9:0]        line_cnt
);

   localparam int LANES  = BUS_W / 8;
   localparam int LANE_W = $clog2(LANES);
   // One spare count above H_BYTES so an over-long line saturates without wrapping back to "good"
   localparam int BC_W   = $clog2(H_BYTES + 2);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_CAP  = 1'b1;

   localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(BUF_STRIDE);
   localparam logic [ADDR_W-1:0] INC_A    = ADDR_W'(WORD_INC);

   logic [0:0]        state_q, state_d;
   logic              href_q, href_d;
   logic [LANE_W-1:0] lane_q, lane_d;
   logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic              err_q, err_d;
   logic [BUS_W-1:0]  word_q, word_d, word_nxt;
   logic [BUS_W-1:0]  p_data_q, p_data_d;
   logic              dv_q, dv_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BUF_W-1:0]  wr_buf_q, wr_buf_d;
   logic [BUF_W-1:0]  last_q, last_d;
   logic              done_q, done_d;
   logic              ferr_q, ferr_d;
   logic              exp_q, exp_d;
   logic [9:0]        line_cnt_q, line_cnt_d;
   logic              line_end;

   always_comb begin
      word_nxt = word_q;
      word_nxt[lane_q*8 +: 8] = data;
   end

   always_comb begin
      state_d    = state_q;
      href_d     = href;
      lane_d     = lane_q;
      byte_cnt_d = byte_cnt_q;
      err_d      = err_q;
      word_d     = word_q;
      p_data_d   = p_data_q;
      dv_d       = 1'b0;
      addr_d     = addr_q;
      wr_buf_d   = wr_buf_q;
      last_d     = last_q;
      done_d     = 1'b0;
      ferr_d     = 1'b0;
      exp_d      = exp_q;
      line_cnt_d = line_cnt_q;
      line_end   = 1'b0;

      if (take_pic) begin
         state_d    = S_IDLE;
         href_d     = 1'b0;
         lane_d     = '0;
         byte_cnt_d = '0;
         exp_d      = 1'b0;
      end else begin
         if (exp_q && exp_ack) exp_d = 1'b0;
         case (state_q)
            S_IDLE: begin
               addr_d     = ADDR_W'(wr_buf_q) * STRIDE_A;
               href_d     = 1'b0;
               lane_d     = '0;
               byte_cnt_d = '0;
               line_cnt_d = '0;
               err_d      = 1'b0;
               if (!vsync) state_d = S_CAP;
            end
            default: begin
               if (dv_q) addr_d = addr_q + INC_A;
               // A line still open when vsync rises is closed together with the frame
               line_end = vsync ? href_q : (href_q && !href);
               if (line_end) begin
                  if (line_cnt_q != '1) line_cnt_d = line_cnt_q + 10'd1;
                  if (byte_cnt_q != BC_W'(H_BYTES)) err_d = 1'b1;
                  lane_d     = '0;
                  byte_cnt_d = '0;
                  if (hdr_en && line_cnt_q == 10'(V_LINES - 1)) exp_d = 1'b1;
               end
               if (vsync) begin
                  state_d = S_IDLE;
                  href_d  = 1'b0;
                  if (line_cnt_d == 10'(V_LINES) && !err_d) begin
                     done_d   = 1'b1;
                     last_d   = wr_buf_q;
                     wr_buf_d = (wr_buf_q == BUF_W'(N_BUF - 1)) ? '0 : wr_buf_q + BUF_W'(1);
                  end else begin
                     ferr_d = 1'b1;
                  end
               end else if (href) begin
                  word_d = word_nxt;
                  if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + BC_W'(1);
                  if (lane_q == LANE_W'(LANES - 1)) begin
                     lane_d   = '0;
                     p_data_d = word_nxt;
                     dv_d     = 1'b1;
                  end else begin
                     lane_d = lane_q + LANE_W'(1);
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge p_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         href_q     <= 1'b0;
         lane_q     <= '0;
         byte_cnt_q <= '0;
         err_q      <= 1'b0;
         word_q     <= '0;
         p_data_q   <= '0;
         dv_q       <= 1'b0;
         addr_q     <= '0;
         wr_buf_q   <= '0;
         last_q     <= '0;
         done_q     <= 1'b0;
         ferr_q     <= 1'b0;
         exp_q      <= 1'b0;
         line_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         href_q     <= href_d;
         lane_q     <= lane_d;
         byte_cnt_q <= byte_cnt_d;
         err_q      <= err_d;
         word_q     <= word_d;
         p_data_q   <= p_data_d;
         dv_q       <= dv_d;
         addr_q     <= addr_d;
         wr_buf_q   <= wr_buf_d;
         last_q     <= last_d;
         done_q     <= done_d;
         ferr_q     <= ferr_d;
         exp_q      <= exp_d;
         line_cnt_q <= line_cnt_d;
      end
   end

   assign p_data     = p_data_q;
   assign data_valid = dv_q;
   assign wr_address = addr_q;
   assign wr_buf     = wr_buf_q;
   assign last_frame = last_q;
   assign frame_done = done_q;
   assign frame_err  = ferr_q;
   assign change_exp = exp_q;
   assign line_cnt   = line_cnt_q;

endmodule

// File: tb/tb_hdr_frame_capture.sv
// Directed bench for hdr_frame_capture: 32-bit words, 8-byte lines, 4-line frames, 3 buffers.
module tb_hdr_frame_capture;

   localparam int H = 8;

   logic        p_clk, rst_n;
   logic [7:0]  data;
   logic        href, vsync, take_pic, hdr_en, exp_ack;
   logic [31:0] p_data;
   logic        data_valid;
   logic [24:0] wr_address;
   logic [2:0]  wr_buf, last_frame;
   logic        frame_done, frame_err, change_exp;
   logic [9:0]  line_cnt;

   int checks = 0;
   int errors = 0;

   logic [31:0] dq[$];
   logic [24:0] aq[$];
   int n_done, n_err, ce_hi, ce_rise;
   int rise_line;
   logic ce_prev;

   hdr_frame_capture #(
      .BUS_W(32), .ADDR_W(25), .H_BYTES(H), .V_LINES(4), .N_BUF(3),
      .BUF_W(3), .BUF_STRIDE('h100), .WORD_INC(1)
   ) dut (
      .p_clk(p_clk), .rst_n(rst_n), .data(data), .href(href), .vsync(vsync),
      .take_pic(take_pic), .hdr_en(hdr_en), .exp_ack(exp_ack),
      .p_data(p_data), .data_valid(data_valid), .wr_address(wr_address),
      .wr_buf(wr_buf), .last_frame(last_frame), .frame_done(frame_done),
      .frame_err(frame_err), .change_exp(change_exp), .line_cnt(line_cnt)
   );

   initial begin
      p_clk = 1'b0;
      forever #5 p_clk = ~p_clk;
   end

   // Output monitor, sampling 2 time units after each rising edge
   initial begin
      n_done = 0; n_err = 0; ce_hi = 0; ce_rise = 0; rise_line = 0; ce_prev = 1'b0;
      forever begin
         @(posedge p_clk);
         #2;
         if (data_valid) begin
            dq.push_back(p_data);
            aq.push_back(wr_address);
         end
         if (frame_done) n_done++;
         if (frame_err) n_err++;
         if (change_exp) ce_hi++;
         if (change_exp && !ce_prev) begin
            ce_rise++;
            rise_line = int'(line_cnt);
         end
         ce_prev = change_exp;
      end
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge p_clk);
   endtask

   task automatic clear_mon();
      dq.delete();
      aq.delete();
      n_done = 0;
      n_err  = 0;
   endtask

   // Blanking, nlines lines (one optionally short), then vsync high; take_pic optionally raised mid-frame
   task automatic send_frame(input int nlines, input int short_ln, input int short_len,
                             input int abort_ln, input int abort_at, input logic [7:0] start);
      logic [7:0] b;
      int len;
      b = start;
      vsync = 1'b1; href = 1'b0; step(3);
      vsync = 1'b0; step(2);
      for (int l = 1; l <= nlines; l++) begin
         len = (l == short_ln) ? short_len : H;
         for (int i = 0; i < len; i++) begin
            if (l == abort_ln && i == abort_at) take_pic = 1'b1;
            href = 1'b1; data = b; b = b + 8'd1;
            step(1);
         end
         href = 1'b0; data = 8'h00;
         step(2);
      end
      vsync = 1'b1;
      step(3);
      take_pic = 1'b0;
      step(1);
   endtask

   initial begin
      rst_n = 1'b0; data = 8'h00; href = 1'b0; vsync = 1'b1;
      take_pic = 1'b0; hdr_en = 1'b0; exp_ack = 1'b0;
      step(2);
      check("rst_p_data", 64'(p_data), 64'h0);
      check("rst_dv", 64'(data_valid), 64'h0);
      check("rst_wr_buf", 64'(wr_buf), 64'h0);
      check("rst_change_exp", 64'(change_exp), 64'h0);
      check("rst_line_cnt", 64'(line_cnt), 64'h0);
      rst_n = 1'b1;
      step(2);

      // Good frame with bytes 0x00..0x1F
      clear_mon();
      send_frame(4, 0, 0, 0, 0, 8'h00);
      check("f1_words", 64'(dq.size()), 64'd8);
      check("f1_first", 64'(dq[0]), 64'h03020100);
      check("f1_first_addr", 64'(aq[0]), 64'h0);
      check("f1_last", 64'(dq[7]), 64'h1F1E1D1C);
      check("f1_last_addr", 64'(aq[7]), 64'h7);
      check("f1_done", 64'(n_done), 64'd1);
      check("f1_err", 64'(n_err), 64'd0);
      check("f1_last_frame", 64'(last_frame), 64'h0);
      check("f1_wr_buf", 64'(wr_buf), 64'h1);

      // Three more good frames: ring buffer rotation
      begin
         logic [24:0] exp_base[3];
         logic [2:0]  exp_buf[3];
         logic [2:0]  exp_last[3];
         exp_base = '{25'h100, 25'h200, 25'h000};
         exp_buf  = '{3'd2, 3'd0, 3'd1};
         exp_last = '{3'd1, 3'd2, 3'd0};
         for (int k = 0; k < 3; k++) begin
            clear_mon();
            send_frame(4, 0, 0, 0, 0, 8'h20);
            check("ring_base", 64'(aq[0]), 64'(exp_base[k]));
            check("ring_wr_buf", 64'(wr_buf), 64'(exp_buf[k]));
            check("ring_last", 64'(last_frame), 64'(exp_last[k]));
            check("ring_done", 64'(n_done), 64'd1);
         end
      end

      // Short second line: partial word dropped, frame flagged
      clear_mon();
      send_frame(4, 2, 6, 0, 0, 8'h40);
      check("short_words", 64'(dq.size()), 64'd7);
      check("short_w2", 64'(dq[2]), 64'h4B4A4948);
      check("short_w3", 64'(dq[3]), 64'h51504F4E);
      check("short_w3_addr", 64'(aq[3]), 64'h103);
      check("short_err", 64'(n_err), 64'd1);
      check("short_done", 64'(n_done), 64'd0);
      check("short_wr_buf", 64'(wr_buf), 64'h1);
      clear_mon();
      send_frame(4, 0, 0, 0, 0, 8'h60);
      check("retry_base", 64'(aq[0]), 64'h100);
      check("retry_done", 64'(n_done), 64'd1);
      check("retry_wr_buf", 64'(wr_buf), 64'h2);
      check("retry_last", 64'(last_frame), 64'h1);

      // Frame one line short
      clear_mon();
      send_frame(3, 0, 0, 0, 0, 8'h70);
      check("l3_err", 64'(n_err), 64'd1);
      check("l3_done", 64'(n_done), 64'd0);
      check("l3_last", 64'(last_frame), 64'h1);
      check("l3_wr_buf", 64'(wr_buf), 64'h2);

      // Exposure request held with no ack
      hdr_en = 1'b1; exp_ack = 1'b0; ce_rise = 0; ce_hi = 0;
      send_frame(4, 0, 0, 0, 0, 8'h00);
      check("exp_rise", 64'(ce_rise), 64'd1);
      check("exp_rise_line", 64'(rise_line), 64'd4);
      check("exp_held", 64'(change_exp), 64'h1);
      exp_ack = 1'b1;
      step(1);
      exp_ack = 1'b0;
      check("exp_cleared", 64'(change_exp), 64'h0);
      // ack already high: one-cycle request per frame
      ce_rise = 0; ce_hi = 0; exp_ack = 1'b1;
      send_frame(4, 0, 0, 0, 0, 8'h00);
      send_frame(4, 0, 0, 0, 0, 8'h00);
      check("exp_per_frame", 64'(ce_rise), 64'd2);
      check("exp_pulse_len", 64'(ce_hi), 64'd2);
      exp_ack = 1'b0; hdr_en = 1'b0;
      send_frame(4, 0, 0, 0, 0, 8'h00);
      check("exp_disabled", 64'(ce_rise), 64'd2);
      send_frame(4, 0, 0, 0, 0, 8'h00);
      check("pre_abort_buf", 64'(wr_buf), 64'h1);

      // take_pic in the middle of line 2
      clear_mon();
      send_frame(4, 0, 0, 2, 2, 8'h80);
      check("abort_words", 64'(dq.size()), 64'd2);
      check("abort_w0", 64'(dq[0]), 64'h83828180);
      check("abort_done", 64'(n_done), 64'd0);
      check("abort_err", 64'(n_err), 64'd0);
      check("abort_wr_buf", 64'(wr_buf), 64'h1);
      check("abort_last", 64'(last_frame), 64'h0);

      // Async reset mid-frame
      vsync = 1'b1; step(2);
      vsync = 1'b0; step(2);
      for (int i = 0; i < H; i++) begin
         href = 1'b1; data = 8'(8'hA0 + i); step(1);
      end
      href = 1'b0; step(2);
      check("pre_rst_line", 64'(line_cnt), 64'd1);
      check("pre_rst_addr", 64'(wr_address), 64'h102);
      href = 1'b1; data = 8'hAA; step(1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_p_data", 64'(p_data), 64'h0);
      check("arst_dv", 64'(data_valid), 64'h0);
      check("arst_addr", 64'(wr_address), 64'h0);
      check("arst_wr_buf", 64'(wr_buf), 64'h0);
      check("arst_last", 64'(last_frame), 64'h0);
      check("arst_done", 64'(frame_done), 64'h0);
      check("arst_err", 64'(frame_err), 64'h0);
      check("arst_exp", 64'(change_exp), 64'h0);
      check("arst_line", 64'(line_cnt), 64'h0);
      href = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
